// File: rtl/fifo_read_adapter.sv
// Converts a registered-read FIFO (empty/r_en/r_data) into a valid/ready stream; optional beat counter under FIFO_RD_CNT_EN.
// Latency: r_en same cycle empty falls, m_valid two cycles later; one beat per cycle sustained.
// Backpressure: 2-entry skid buffer absorbs the in-flight read word; r_en drops when the buffer would overfill.
module fifo_read_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            occ;
    logic [1:0]            occ_nxt;
    logic                  inflight;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    assign pop     = m_valid && m_ready;
    // A pop only happens with occ >= 1, so this never underflows; max is 2.
    assign occ_nxt = occ + {1'b0, inflight} - {1'b0, pop};
    assign r_en    = rrst_n && !empty && (occ_nxt < ST_FULL);
    assign m_data  = head_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ      <= ST_EMPTY;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= r_en;
            m_valid  <= (occ_nxt != ST_EMPTY);
            // The returning word is always accepted: r_en was only issued with a free slot.
            case (occ)
                ST_EMPTY: begin
                    if (inflight) head_q <= r_data;
                end
                ST_ONE: begin
                    if (inflight) begin
                        if (pop) head_q <= r_data;
                        else     tail_q <= r_data;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (inflight) tail_q <= r_data;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Directed bench for fifo_read_adapter with a registered-read FIFO model and an in-order scoreboard.
module tb_fifo_read_adapter;

    localparam int DW = 8;

    logic          rclk;
    logic          rrst_n;
    logic          empty;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [3:0]    beat_cnt;
`endif

    fifo_read_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .empty   (empty),
        .r_en    (r_en),
        .r_data  (r_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .beat_cnt(beat_cnt)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int            checks;
    int            errors;
    int            cyc;
    int            ren_count;
    int            beat_count;
    int            first_ren;
    int            first_beat;
    int            last_beat;
    int            n;
    logic          ren_s;
    logic          hold_empty;
    logic [DW-1:0] held;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic upd_empty();
        empty = (fifo_q.size() == 0) || hold_empty;
    endtask

    // One clock: check/score at the falling edge, then model the FIFO's registered read just after the rising edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge rclk);
        chk("ren_while_empty", 32'(r_en & empty), 32'd0);
        if (r_en) begin
            ren_count++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (m_valid && m_ready) begin
            beat_count++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(m_data), 32'(e));
            end
        end
        ren_s = r_en;
        @(posedge rclk);
        #1;
        cyc++;
        if (ren_s && fifo_q.size() != 0) r_data = fifo_q.pop_front();
        upd_empty();
    endtask

    task automatic clr_stats();
        ren_count  = 0;
        beat_count = 0;
        first_ren  = -1;
        first_beat = -1;
        last_beat  = -1;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        hold_empty = 1'b0;
        ren_s = 1'b0;
        clr_stats();
        rrst_n = 1'b0; empty = 1'b0; m_ready = 1'b1; r_data = '0;
        #2;
        // Reset state, with empty low to prove r_en is held off.
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_r_en", 32'(r_en), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
        empty = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;

        // Stream of 8 words with m_ready high.
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        upd_empty();
        clr_stats();
        repeat (14) tick();
        chk("stream_latency", 32'(first_beat - first_ren), 32'd2);
        chk("stream_beats", 32'(beat_count), 32'd8);
        chk("stream_consecutive", 32'(last_beat - first_beat), 32'd7);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_idle_valid", 32'(m_valid), 32'd0);

        // Backpressure for 5 cycles mid-stream.
        for (int i = 0; i < 16; i++) push_word(DW'(8'h10 + i));
        upd_empty();
        repeat (4) tick();
        m_ready = 1'b0;
        held = m_data;
        repeat (5) tick();
        chk("bp_occ_full", 32'(dut.occ), 32'd2);
        chk("bp_r_en_low", 32'(r_en), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data_held", 32'(m_data), 32'(held));
        m_ready = 1'b1;
        repeat (25) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Single word then empty.
        clr_stats();
        push_word(8'hA5);
        upd_empty();
        repeat (6) tick();
        chk("one_ren_pulses", 32'(ren_count), 32'd1);
        chk("one_beats", 32'(beat_count), 32'd1);
        chk("one_valid_after", 32'(m_valid), 32'd0);

        // Reset in the middle of a transfer; FIFO is cleared in the same domain.
        for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
        upd_empty();
        repeat (4) tick();
        rrst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_r_en", 32'(r_en), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        r_data = '0;
        upd_empty();
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        clr_stats();
        repeat (6) tick();
        chk("midrst_no_stale", 32'(beat_count), 32'd0);
        chk("midrst_valid_low", 32'(m_valid), 32'd0);

        // Random empty and m_ready over 1000 words.
        for (int i = 0; i < 1000; i++) push_word(DW'($urandom_range(0, 255)));
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            m_ready = ($urandom_range(0, 1) == 1);
            hold_empty = ($urandom_range(0, 2) == 0);
            upd_empty();
            tick();
            n++;
        end
        hold_empty = 1'b0;
        m_ready = 1'b1;
        upd_empty();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
        chk("rand_idle_valid", 32'(m_valid), 32'd0);

`ifdef FIFO_RD_CNT_EN
        // 17 beats on a 4-bit counter wrap to 1.
        rrst_n = 1'b0;
        #1;
        chk("cnt_rst", 32'(beat_cnt), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        for (int i = 0; i < 17; i++) push_word(DW'(8'h60 + i));
        upd_empty();
        repeat (25) tick();
        chk("cnt_wrap", 32'(beat_cnt), 32'd1);
        chk("cnt_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_adapter.md
FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word and stream data width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the delivered-beat counter width (used only under REQ-026).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named rclk and rrst_n.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 empty  input  1  FIFO empty flag, synchronous to rclk.
REQ-007 r_en  output  1  FIFO pop strobe; one word removed per cycle high.
REQ-008 r_data  input  DATA_WIDTH  FIFO read data, valid exactly one cycle after the r_en cycle (registered memory read).
REQ-009 m_valid  output  1  stream data valid.
REQ-010 m_data  output  DATA_WIDTH  stream data.
REQ-011 m_ready  input  1  downstream accepts; a beat transfers in any cycle where m_valid and m_ready are both high.

Function
REQ-012 The block SHALL hold a 2-entry output buffer (occ 0..2) and a 1-bit in-flight flag marking that r_en was high in the previous cycle.
REQ-013 Buffer states SHALL be EMPTY (occ=0), ONE (occ=1) and FULL (occ=2). Next occ = occ + inflight - pop, where pop = m_valid && m_ready.
REQ-014 r_en SHALL be combinational: r_en = !empty && (occ + inflight - pop) < 2. It SHALL never be high while empty is high.
REQ-015 When inflight is 1, r_data SHALL be written into the buffer tail in that cycle, unconditionally. REQ-014 guarantees a free slot.
REQ-016 m_valid SHALL equal (occ != 0), registered. m_data SHALL be the head entry and SHALL be stable while m_valid && !m_ready.
REQ-017 Word order on m_data SHALL equal the FIFO pop order; no word is dropped or duplicated.
REQ-018 Latency: with the buffer EMPTY and empty falling, r_en rises the same cycle and m_valid rises 2 cycles later.
REQ-019 Throughput SHALL be one beat per cycle while the FIFO is non-empty and m_ready is held high.
REQ-020 In FULL with m_ready low, r_en SHALL stay low.
REQ-021 A simultaneous write (inflight) and pop in ONE SHALL leave the state at ONE, with the head replaced by the incoming word.
REQ-022 A pop in FULL with inflight 0 SHALL shift entry 1 to head; the state goes to ONE.

Reset
REQ-023 While rrst_n is low, the block SHALL force: occ=0, inflight=0, m_valid=0, r_en=0, m_data=0, beat_cnt=0.
REQ-024 Reset asserted mid-transfer SHALL discard buffered and in-flight words. Release SHALL take effect on the first rclk edge after rrst_n rises. The FIFO SHALL be reset in the same reset domain.

Configuration
REQ-025 Macro FIFO_RD_CNT_EN SHALL select the beat-counter feature.
REQ-026 With FIFO_RD_CNT_EN defined, the block SHALL add output beat_cnt (CNT_WIDTH bits). beat_cnt increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
REQ-027 Without FIFO_RD_CNT_EN, the block SHALL have no beat_cnt port, no counter logic, and otherwise identical behaviour.

Verification
REQ-028 Reset: rrst_n=0 during streaming -> m_valid=0, r_en=0 immediately; after release, no stale word appears.
REQ-029 Stream: FIFO preloaded with 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, first beat 2 cycles after the first r_en.
REQ-030 Backpressure: m_ready=0 for 5 cycles mid-stream -> occ reaches 2, r_en low, m_data held; order intact after release.
REQ-031 Empty boundary: FIFO holds 1 word (0xA5), then empty=1 -> exactly one r_en pulse, one beat 0xA5, then m_valid=0.
REQ-032 Random: 1000 words with random empty and m_ready -> scoreboard sees no loss, duplication or reorder, and r_en never coincides with empty=1.
REQ-033 FIFO_RD_CNT_EN with CNT_WIDTH=4: 17 beats -> beat_cnt=1 (wrapped).
